// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serial memory responder.
// Holds the state and owner encodings, the transfer lengths and the length normaliser.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_FIN  = 2'd3
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_MM = 1'b1
    } owner_e;

    localparam logic [2:0] LEN_B = 3'd1;
    localparam logic [2:0] LEN_H = 3'd2;
    localparam logic [2:0] LEN_W = 3'd4;

    // Any length code other than byte/half is served as a full word.
    function automatic logic [2:0] norm_len(input logic [2:0] len);
        return ((len == LEN_B) || (len == LEN_H)) ? len : LEN_W;
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Request/busy/done bundle for the IF and MEM ports plus the byte-wide RAM side.
// slave = the controller; master = the requesting stages and the RAM.
interface mem_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_re;
    logic [ADDR_W-1:0] if_addr;
    logic              if_busy;
    logic              if_done;
    logic [DATA_W-1:0] if_data;

    logic              mm_re;
    logic              mm_we;
    logic [2:0]        mm_len;
    logic [ADDR_W-1:0] mm_addr;
    logic [DATA_W-1:0] mm_wdata;
    logic              mm_busy;
    logic              mm_done;
    logic [DATA_W-1:0] mm_rdata;

    logic [ADDR_W-1:0] ram_addr;
    logic              ram_wr;
    logic [7:0]        ram_dout;
    logic [7:0]        ram_din;

    modport slave (
        input  if_re, if_addr, mm_re, mm_we, mm_len, mm_addr, mm_wdata, ram_din,
        output if_busy, if_done, if_data, mm_busy, mm_done, mm_rdata,
               ram_addr, ram_wr, ram_dout
    );

    modport master (
        output if_re, if_addr, mm_re, mm_we, mm_len, mm_addr, mm_wdata, ram_din,
        input  if_busy, if_done, if_data, mm_busy, mm_done, mm_rdata,
               ram_addr, ram_wr, ram_dout
    );
endinterface

// File: rtl/mem_ctrl.sv
// Serves IF word reads and MEM 1/2/4-byte reads/writes over a byte-wide synchronous RAM.
// MEM has fixed priority; every output is a flop so busy never loops back into the requester.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic      clk,
    input  logic      rst,
    mem_ctrl_if.slave bus
);

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [2:0]        len_q, len_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              if_pend_q, if_pend_d;
    logic              mm_pend_q, mm_pend_d;
    logic              if_busy_q, if_busy_d;
    logic              if_done_q, if_done_d;
    logic              mm_busy_q, mm_busy_d;
    logic              mm_done_q, mm_done_d;
    logic [DATA_W-1:0] if_data_q, if_data_d;
    logic [DATA_W-1:0] mm_rdata_q, mm_rdata_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              ram_wr_q, ram_wr_d;
    logic [7:0]        ram_dout_q, ram_dout_d;

    logic              mm_req;
    logic [1:0]        rd_byte;

    assign mm_req  = bus.mm_re | bus.mm_we;
    // RAM data lags the address by one cycle, so count cnt lands in byte cnt-1.
    assign rd_byte = 2'(cnt_q - 3'd1);

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        base_d     = base_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        if_data_d  = if_data_q;
        mm_rdata_d = mm_rdata_q;
        ram_addr_d = ram_addr_q;
        ram_dout_d = ram_dout_q;
        if_pend_d  = if_pend_q | bus.if_re;
        mm_pend_d  = mm_pend_q | mm_req;

        unique case (state_q)
            ST_IDLE: begin
                if (mm_pend_q || mm_req) begin
                    owner_d    = OWN_MM;
                    base_d     = bus.mm_addr;
                    len_d      = norm_len(bus.mm_len);
                    cnt_d      = 3'd0;
                    state_d    = bus.mm_we ? ST_WR : ST_RD;
                    shift_d    = bus.mm_we ? bus.mm_wdata : '0;
                    ram_addr_d = bus.mm_addr;
                    ram_dout_d = bus.mm_wdata[7:0];
                end else if (if_pend_q || bus.if_re) begin
                    owner_d    = OWN_IF;
                    base_d     = bus.if_addr;
                    len_d      = LEN_W;
                    cnt_d      = 3'd0;
                    state_d    = ST_RD;
                    shift_d    = '0;
                    ram_addr_d = bus.if_addr;
                end
            end
            ST_RD: begin
                if (cnt_q != 3'd0) begin
                    shift_d[{rd_byte, 3'b000} +: 8] = bus.ram_din;
                end
                if (cnt_q == len_q) begin
                    state_d = ST_FIN;
                    if (owner_q == OWN_IF) begin
                        if_data_d = shift_d;
                    end else begin
                        mm_rdata_d = shift_d;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_d < len_q) begin
                        ram_addr_d = base_q + ADDR_W'(cnt_d);
                    end
                end
            end
            ST_WR: begin
                if (cnt_q == len_q - 3'd1) begin
                    state_d = ST_FIN;
                end else begin
                    cnt_d      = cnt_q + 3'd1;
                    ram_addr_d = base_q + ADDR_W'(cnt_d);
                    ram_dout_d = shift_q[{cnt_d[1:0], 3'b000} +: 8];
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
                // Clearing wins over a fresh request from the same port in this cycle.
                if (owner_q == OWN_IF) begin
                    if_pend_d = 1'b0;
                end else begin
                    mm_pend_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if_done_d = (state_d == ST_FIN) && (owner_d == OWN_IF);
        mm_done_d = (state_d == ST_FIN) && (owner_d == OWN_MM);
        if_busy_d = if_pend_d && !if_done_d;
        mm_busy_d = mm_pend_d && !mm_done_d;
        ram_wr_d  = (state_d == ST_WR);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWN_IF;
            base_q     <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            shift_q    <= '0;
            if_pend_q  <= 1'b0;
            mm_pend_q  <= 1'b0;
            if_busy_q  <= 1'b0;
            if_done_q  <= 1'b0;
            mm_busy_q  <= 1'b0;
            mm_done_q  <= 1'b0;
            if_data_q  <= '0;
            mm_rdata_q <= '0;
            ram_addr_q <= '0;
            ram_wr_q   <= 1'b0;
            ram_dout_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            base_q     <= base_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            if_pend_q  <= if_pend_d;
            mm_pend_q  <= mm_pend_d;
            if_busy_q  <= if_busy_d;
            if_done_q  <= if_done_d;
            mm_busy_q  <= mm_busy_d;
            mm_done_q  <= mm_done_d;
            if_data_q  <= if_data_d;
            mm_rdata_q <= mm_rdata_d;
            ram_addr_q <= ram_addr_d;
            ram_wr_q   <= ram_wr_d;
            ram_dout_q <= ram_dout_d;
        end
    end

    assign bus.if_busy  = if_busy_q;
    assign bus.if_done  = if_done_q;
    assign bus.if_data  = if_data_q;
    assign bus.mm_busy  = mm_busy_q;
    assign bus.mm_done  = mm_done_q;
    assign bus.mm_rdata = mm_rdata_q;
    assign bus.ram_addr = ram_addr_q;
    assign bus.ram_wr   = ram_wr_q;
    assign bus.ram_dout = ram_dout_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: directed handshake scenarios plus randomized transactions
// checked against a transaction-level memory model (latency = bytes + 2 read, bytes + 1 write).
`timescale 1ns/1ps
module tb_mem_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    mem_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (.clk(clk), .rst(rst_n), .bus(bus));

    // RAM environment: 4 KiB aliased by the low address bits, one-cycle read latency.
    logic [7:0]  ram_mem   [0:4095];
    bit          ram_valid [0:4095];
    logic [7:0]  ref_mem   [0:4095];
    logic [31:0] wr_addr_log [$];
    logic [7:0]  wr_data_log [$];
    logic        poke_en = 1'b0;
    logic [11:0] poke_addr = '0;
    logic [7:0]  poke_data = '0;
    int n_checks = 0;
    int n_pass   = 0;

    function automatic logic [7:0] init_pat(input logic [11:0] a);
        return a[7:0] ^ {a[11:8], a[11:8]} ^ 8'hA5;
    endfunction

    always @(posedge clk) begin
        bus.ram_din <= ram_valid[bus.ram_addr[11:0]] ? ram_mem[bus.ram_addr[11:0]]
                                                     : init_pat(bus.ram_addr[11:0]);
        if (bus.ram_wr) begin
            ram_mem[bus.ram_addr[11:0]]   <= bus.ram_dout;
            ram_valid[bus.ram_addr[11:0]] <= 1'b1;
            wr_addr_log.push_back(bus.ram_addr);
            wr_data_log.push_back(bus.ram_dout);
        end else if (poke_en) begin
            ram_mem[poke_addr]   <= poke_data;
            ram_valid[poke_addr] <= 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [31:0] a, input logic [7:0] v);
        poke_en = 1'b1; poke_addr = a[11:0]; poke_data = v;
        ref_mem[a[11:0]] = v;
        tick();
        poke_en = 1'b0;
    endtask

    function automatic logic [31:0] ref_read(input logic [31:0] a, input int nbytes);
        logic [31:0] r;
        logic [31:0] ak;
        r = '0;
        for (int k = 0; k < nbytes; k++) begin
            ak = a + 32'(k);
            r[8*k +: 8] = ref_mem[ak[11:0]];
        end
        return r;
    endfunction

    task automatic issue_mm(input logic re, input logic we, input logic [2:0] len,
                            input logic [31:0] addr, input logic [31:0] wdata);
        bus.mm_re = re; bus.mm_we = we; bus.mm_len = len;
        bus.mm_addr = addr; bus.mm_wdata = wdata;
        tick();
        bus.mm_re = 1'b0; bus.mm_we = 1'b0;
    endtask

    task automatic issue_if(input logic [31:0] addr);
        bus.if_addr = addr; bus.if_re = 1'b1;
        tick();
        bus.if_re = 1'b0;
    endtask

    task automatic wait_done(input bit is_mm, input int start, output int lat);
        lat = start;
        while (((is_mm ? bus.mm_done : bus.if_done) !== 1'b1) && lat < 30) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        tick(); tick();
        n_checks++;
        if ({bus.if_busy, bus.if_done, bus.mm_busy, bus.mm_done, bus.ram_wr} !== 5'b0)
            $display("FAIL reset_flags got=%b exp=00000",
                     {bus.if_busy, bus.if_done, bus.mm_busy, bus.mm_done, bus.ram_wr});
        else n_pass++;
        n_checks++;
        if ({bus.if_data, bus.mm_rdata} !== 64'h0)
            $display("FAIL reset_data got=%h exp=0", {bus.if_data, bus.mm_rdata});
        else n_pass++;
        n_checks++;
        if ({bus.ram_addr, bus.ram_dout} !== 40'h0)
            $display("FAIL reset_ram got=%h exp=0", {bus.ram_addr, bus.ram_dout});
        else n_pass++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_if_read();
        poke(32'h100, 8'h78); poke(32'h101, 8'h56); poke(32'h102, 8'h34); poke(32'h103, 8'h12);
        issue_if(32'h100);
        for (int c = 1; c <= 6; c++) begin
            n_checks++;
            if (bus.if_busy !== (c < 6))
                $display("FAIL if_read_busy A+%0d got=%b exp=%b", c, bus.if_busy, (c < 6));
            else n_pass++;
            n_checks++;
            if (bus.if_done !== (c == 6))
                $display("FAIL if_read_done A+%0d got=%b exp=%b", c, bus.if_done, (c == 6));
            else n_pass++;
            if (c < 6) tick();
        end
        n_checks++;
        if (bus.if_data !== 32'h12345678)
            $display("FAIL if_read_data got=%h exp=12345678", bus.if_data);
        else n_pass++;
        $display("txn IF lw 0x100 data=%h", bus.if_data);
        tick();
    endtask

    task automatic test_mm_sw();
        int          log0;
        logic [31:0] wd;
        log0 = wr_addr_log.size();
        wd   = 32'hDEADBEEF;
        issue_mm(1'b0, 1'b1, 3'd4, 32'h200, wd);
        for (int c = 1; c <= 5; c++) begin
            n_checks++;
            if (bus.mm_done !== (c == 5))
                $display("FAIL sw_done A+%0d got=%b exp=%b", c, bus.mm_done, (c == 5));
            else n_pass++;
            if (c < 5) tick();
        end
        n_checks++;
        if (wr_addr_log.size() - log0 !== 4)
            $display("FAIL sw_wr_count got=%0d exp=4", wr_addr_log.size() - log0);
        else begin
            n_pass++;
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if (wr_addr_log[log0+k] !== 32'h200 + 32'(k) || wr_data_log[log0+k] !== wd[8*k +: 8])
                    $display("FAIL sw_wr%0d got=%h:%h exp=%h:%h", k, wr_addr_log[log0+k],
                             wr_data_log[log0+k], 32'h200 + 32'(k), wd[8*k +: 8]);
                else n_pass++;
            end
        end
        for (int k = 0; k < 4; k++) ref_mem[12'h200 + 12'(k)] = wd[8*k +: 8];
        $display("txn MM sw 0x200 data=%h", wd);
        tick();
    endtask

    task automatic test_mm_lb_sh();
        int lat;
        int log0;
        issue_mm(1'b1, 1'b0, 3'd1, 32'h201, 32'h0);
        wait_done(1'b1, 1, lat);
        n_checks++;
        if (lat !== 3) $display("FAIL lb_latency got=%0d exp=3", lat); else n_pass++;
        n_checks++;
        if (bus.mm_rdata !== 32'h000000BE)
            $display("FAIL lb_data got=%h exp=000000be", bus.mm_rdata);
        else n_pass++;
        $display("txn MM lb 0x201 data=%h", bus.mm_rdata);
        tick();
        log0 = wr_addr_log.size();
        issue_mm(1'b0, 1'b1, 3'd2, 32'h300, 32'h0000AABB);
        wait_done(1'b1, 1, lat);
        n_checks++;
        if (lat !== 3) $display("FAIL sh_latency got=%0d exp=3", lat); else n_pass++;
        n_checks++;
        if (wr_addr_log.size() - log0 !== 2 || wr_data_log[log0] !== 8'hBB || wr_data_log[log0+1] !== 8'hAA
            || wr_addr_log[log0+1] !== 32'h301)
            $display("FAIL sh_writes got_count=%0d exp_count=2 (bytes BB@300 AA@301)",
                     wr_addr_log.size() - log0);
        else n_pass++;
        ref_mem[12'h300] = 8'hBB; ref_mem[12'h301] = 8'hAA;
        $display("txn MM sh 0x300 data=0000aabb");
        tick();
    endtask

    task automatic test_both();
        int          mm_at;
        int          if_at;
        logic [31:0] exp_if;
        logic [31:0] exp_mm;
        mm_at  = 4 + 2;           // MEM word read served first
        if_at  = mm_at + 1 + 6;   // one IDLE cycle, then a full IF word read
        exp_if = ref_read(32'h100, 4);
        exp_mm = ref_read(32'h200, 4);
        bus.if_addr = 32'h100; bus.if_re = 1'b1;
        issue_mm(1'b1, 1'b0, 3'd4, 32'h200, 32'h0);
        bus.if_re = 1'b0;
        for (int c = 1; c <= if_at; c++) begin
            n_checks++;
            if (bus.if_busy !== (c < if_at))
                $display("FAIL both_if_busy A+%0d got=%b exp=%b", c, bus.if_busy, (c < if_at));
            else n_pass++;
            n_checks++;
            if (bus.mm_done !== (c == mm_at) || bus.if_done !== (c == if_at))
                $display("FAIL both_done A+%0d got=mm%b/if%b exp=mm%b/if%b", c, bus.mm_done,
                         bus.if_done, (c == mm_at), (c == if_at));
            else n_pass++;
            if (c < if_at) tick();
        end
        n_checks++;
        if (bus.mm_rdata !== exp_mm || bus.if_data !== exp_if)
            $display("FAIL both_data got=%h/%h exp=%h/%h", bus.mm_rdata, bus.if_data, exp_mm, exp_if);
        else n_pass++;
        $display("txn MM lw 0x200 + IF lw 0x100 same cycle data=%h/%h", bus.mm_rdata, bus.if_data);
        tick();
    endtask

    task automatic test_wrap();
        int          lat;
        logic [31:0] exp_a;
        logic [31:0] exp_w;
        exp_w = ref_read(32'hFFFFFFFE, 4);
        issue_if(32'hFFFFFFFE);
        for (int c = 1; c <= 4; c++) begin
            exp_a = 32'hFFFFFFFE + 32'(c - 1);
            n_checks++;
            if (bus.ram_addr !== exp_a)
                $display("FAIL wrap_addr A+%0d got=%h exp=%h", c, bus.ram_addr, exp_a);
            else n_pass++;
            if (c < 4) tick();
        end
        wait_done(1'b0, 4, lat);
        n_checks++;
        if (lat !== 6 || bus.if_data !== exp_w)
            $display("FAIL wrap_read got=lat%0d/%h exp=lat6/%h", lat, bus.if_data, exp_w);
        else n_pass++;
        $display("txn IF lw 0xfffffffe data=%h", bus.if_data);
        tick();
    endtask

    task automatic test_reset_mid();
        int          lat;
        logic [31:0] exp_w;
        exp_w = ref_read(32'h100, 4);
        issue_if(32'h104);
        tick(); tick();
        #3 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.if_busy, bus.if_done, bus.mm_busy, bus.mm_done, bus.ram_wr} !== 5'b0)
            $display("FAIL midrst_flags got=%b exp=00000",
                     {bus.if_busy, bus.if_done, bus.mm_busy, bus.mm_done, bus.ram_wr});
        else n_pass++;
        n_checks++;
        if ({bus.if_data, bus.mm_rdata, bus.ram_addr, bus.ram_dout} !== 104'h0)
            $display("FAIL midrst_regs got=%h exp=0", {bus.if_data, bus.mm_rdata, bus.ram_addr});
        else n_pass++;
        #1 rst_n = 1'b1;
        tick();
        n_checks++;
        if (bus.if_busy !== 1'b0) $display("FAIL midrst_pend got=%b exp=0", bus.if_busy); else n_pass++;
        issue_if(32'h100);
        wait_done(1'b0, 1, lat);
        n_checks++;
        if (lat !== 6 || bus.if_data !== exp_w)
            $display("FAIL midrst_reread got=lat%0d/%h exp=lat6/%h", lat, bus.if_data, exp_w);
        else n_pass++;
        $display("txn IF lw 0x100 after reset data=%h", bus.if_data);
        tick();
    endtask

    task automatic test_random();
        bit          is_mm;
        bit          wr;
        int          op;
        int          nl;
        int          lat;
        int          exp_lat;
        logic [2:0]  len;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_d;
        logic [31:0] got_d;
        logic [31:0] ak;
        for (int t = 0; t < 40; t++) begin
            is_mm = ($urandom_range(0, 2) != 0);
            addr  = $urandom;
            wdata = $urandom;
            len   = 3'($urandom_range(0, 7));
            op    = $urandom_range(0, 2);
            wr    = is_mm && (op != 0);
            nl    = !is_mm ? 4 : ((len == 3'd1 || len == 3'd2) ? int'(len) : 4);
            exp_lat = wr ? nl + 1 : nl + 2;
            exp_d   = wr ? '0 : ref_read(addr, nl);
            if (is_mm) issue_mm(op != 1, op != 0, len, addr, wdata);
            else       issue_if(addr);
            n_checks++;
            if ((is_mm ? bus.mm_busy : bus.if_busy) !== 1'b1)
                $display("FAIL rnd%0d_busy got=0 exp=1", t);
            else n_pass++;
            wait_done(is_mm, 1, lat);
            n_checks++;
            if (lat !== exp_lat || (is_mm ? bus.mm_busy : bus.if_busy) !== 1'b0)
                $display("FAIL rnd%0d_done got=lat%0d exp=lat%0d", t, lat, exp_lat);
            else n_pass++;
            if (wr) begin
                got_d = '0;
                for (int k = 0; k < nl; k++) begin
                    ak = addr + 32'(k);
                    ref_mem[ak[11:0]] = wdata[8*k +: 8];
                    exp_d[8*k +: 8] = wdata[8*k +: 8];
                    got_d[8*k +: 8] = ram_valid[ak[11:0]] ? ram_mem[ak[11:0]] : 8'hxx;
                end
            end else begin
                got_d = is_mm ? bus.mm_rdata : bus.if_data;
            end
            n_checks++;
            if (got_d !== exp_d)
                $display("FAIL rnd%0d_data got=%h exp=%h", t, got_d, exp_d);
            else n_pass++;
            $display("txn rnd%0d %s %s addr=%h len=%0d data=%h lat=%0d", t, is_mm ? "MM" : "IF",
                     wr ? "wr" : "rd", addr, nl, got_d, lat);
            tick();
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
        end
    endtask

    initial begin
        bus.if_re = 1'b0; bus.if_addr = '0;
        bus.mm_re = 1'b0; bus.mm_we = 1'b0; bus.mm_len = '0; bus.mm_addr = '0; bus.mm_wdata = '0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = init_pat(12'(i));
        test_reset();
        test_if_read();
        test_mm_sw();
        test_mm_lb_sh();
        test_both();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
